clint_timecmp_sched: RTL and testbench

- Multiplexes NUM_TIMERS software deadline slots onto the single per-hart mtimecmp register of the CLINT.
- Keeps the earliest armed deadline programmed through a simple single-beat register-write port, which is bridged to the CLINT AXI slave.
- On CLINT timer_irq, marks expired slots pending and reprograms mtimecmp.
- Sits between the platform timer-service logic and the CLINT.

---
 rtl/clint_timecmp_sched_if.sv | 27 ++
 rtl/clint_timecmp_sched.sv | 161 ++++++++++++++++
 tb/tb_clint_timecmp_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/clint_timecmp_sched_if.sv
// Bundles the slot-configuration handshake and the single-beat register-write
// port that is bridged to the CLINT AXI slave.
interface clint_timecmp_sched_if #(
  parameter int NUM_TIMERS = 4
);
  localparam int IW = $clog2(NUM_TIMERS);

  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [IW-1:0] cfg_idx_i;
  logic          cfg_arm_i;
  logic [63:0]   cfg_deadline_i;
  logic          wr_valid_o;
  logic          wr_ready_i;
  logic [31:0]   wr_addr_o;
  logic [31:0]   wr_data_o;

  modport slave (
    input  cfg_valid_i, cfg_idx_i, cfg_arm_i, cfg_deadline_i, wr_ready_i,
    output cfg_ready_o, wr_valid_o, wr_addr_o, wr_data_o
  );

  modport master (
    output cfg_valid_i, cfg_idx_i, cfg_arm_i, cfg_deadline_i, wr_ready_i,
    input  cfg_ready_o, wr_valid_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/clint_timecmp_sched.sv
// Multiplexes NUM_TIMERS deadline slots onto one CLINT mtimecmp register.
// Optional saturating spurious-irq counter: CLINT_SCHED_SPURIOUS_CNT_EN.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | accepting cfg, waiting for timer irq
// S_EXPIRE    | mark armed slots with deadline <= mtime pending, disarm them
// S_SCAN      | one slot per cycle, find earliest armed deadline
// S_WR_LO_MAX | mtimecmp[31:0] <= all-ones so no false irq between halves
// S_WR_HI     | mtimecmp[63:32] <= min[63:32]
// S_WR_LO     | mtimecmp[31:0] <= min[31:0], then record cur_cmp
module clint_timecmp_sched #(
  parameter int          NUM_TIMERS = 4,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter int          HART_ID    = 0
) (
  input  logic                  clk,
  input  logic                  ndmreset_n,
  clint_timecmp_sched_if.slave  bus,
  input  logic [63:0]           mtime_i,
  input  logic                  timer_irq_i,
  input  logic [NUM_TIMERS-1:0] pend_clr_i,
  output logic [NUM_TIMERS-1:0] pend_o,
  output logic                  irq_o,
  output logic                  busy_o,
  output logic [15:0]           spurious_cnt_o
);
  localparam int          IW         = $clog2(NUM_TIMERS);
  localparam logic [31:0] LP_ADDR_LO = CLINT_BASE + 32'h4000 + 32'(8 * HART_ID);
  localparam logic [31:0] LP_ADDR_HI = LP_ADDR_LO + 32'd4;
  localparam logic [IW-1:0] LP_LAST  = IW'(NUM_TIMERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXPIRE, S_SCAN, S_WR_LO_MAX, S_WR_HI, S_WR_LO
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_TIMERS-1:0] r_armed, r_pend, w_expired;
  logic [63:0]           r_deadline [NUM_TIMERS];
  logic [IW-1:0]         r_idx, w_cfg_idx;
  logic [63:0]           r_min, r_cur_cmp, w_min_nxt;
  logic                  r_irq_seen, w_irq_evt, w_cfg_acc;
  logic                  w_cfg_ready, w_wr_valid;
  logic [31:0]           w_wr_addr, w_wr_data;

  assign w_cfg_idx = bus.cfg_idx_i;
  assign w_irq_evt = timer_irq_i || r_irq_seen;
  assign w_cfg_acc = bus.cfg_valid_i && (r_state == S_IDLE);

  always_comb begin
    w_expired = '0;
    for (int i = 0; i < NUM_TIMERS; i++)
      w_expired[i] = r_armed[i] && (r_deadline[i] <= mtime_i);
  end

  // strict '<' keeps the lower index on ties
  assign w_min_nxt = (r_armed[r_idx] && (r_deadline[r_idx] < r_min)) ? r_deadline[r_idx] : r_min;

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_ready = 1'b0;
    w_wr_valid  = 1'b0;
    w_wr_addr   = '0;
    w_wr_data   = '0;
    case (r_state)
      S_IDLE: begin
        w_cfg_ready = 1'b1;
        if (bus.cfg_valid_i || w_irq_evt) w_state_nxt = S_EXPIRE;
      end
      S_EXPIRE: w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (r_idx == LP_LAST)
          w_state_nxt = (w_min_nxt != r_cur_cmp) ? S_WR_LO_MAX : S_IDLE;
      end
      S_WR_LO_MAX: begin
        w_wr_valid = 1'b1;
        w_wr_addr  = LP_ADDR_LO;
        w_wr_data  = 32'hFFFF_FFFF;
        if (bus.wr_ready_i) w_state_nxt = S_WR_HI;
      end
      S_WR_HI: begin
        w_wr_valid = 1'b1;
        w_wr_addr  = LP_ADDR_HI;
        w_wr_data  = r_min[63:32];
        if (bus.wr_ready_i) w_state_nxt = S_WR_LO;
      end
      S_WR_LO: begin
        w_wr_valid = 1'b1;
        w_wr_addr  = LP_ADDR_LO;
        w_wr_data  = r_min[31:0];
        if (bus.wr_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ndmreset_n) begin
    if (!ndmreset_n) begin
      r_state    <= S_SCAN;
      r_idx      <= '0;
      r_min      <= '1;
      r_cur_cmp  <= '0;
      r_armed    <= '0;
      r_pend     <= '0;
      r_irq_seen <= 1'b0;
      for (int i = 0; i < NUM_TIMERS; i++) r_deadline[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= (r_pend & ~pend_clr_i) | ((r_state == S_EXPIRE) ? w_expired : '0);
      if (r_state == S_IDLE) r_irq_seen <= 1'b0;
      else if (timer_irq_i)  r_irq_seen <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_cfg_acc) begin
            r_armed[w_cfg_idx]    <= bus.cfg_arm_i;
            r_deadline[w_cfg_idx] <= bus.cfg_deadline_i;
          end
        end
        S_EXPIRE: begin
          r_armed <= r_armed & ~w_expired;
          r_idx   <= '0;
          r_min   <= '1;
        end
        S_SCAN: begin
          r_min <= w_min_nxt;
          r_idx <= r_idx + IW'(1);
        end
        S_WR_LO: if (bus.wr_ready_i) r_cur_cmp <= r_min;
        default: ;
      endcase
    end
  end

`ifdef CLINT_SCHED_SPURIOUS_CNT_EN
  logic        r_exp_irq;
  logic [15:0] r_spurious;

  always_ff @(posedge clk or negedge ndmreset_n) begin
    if (!ndmreset_n) begin
      r_exp_irq  <= 1'b0;
      r_spurious <= '0;
    end else begin
      if (r_state == S_IDLE) r_exp_irq <= w_irq_evt;
      if ((r_state == S_EXPIRE) && r_exp_irq && (w_expired == '0) && (r_spurious != 16'hFFFF))
        r_spurious <= r_spurious + 16'd1;
    end
  end

  assign spurious_cnt_o = r_spurious;
`else
  assign spurious_cnt_o = 16'h0;
`endif

  assign bus.cfg_ready_o = w_cfg_ready;
  assign bus.wr_valid_o  = w_wr_valid;
  assign bus.wr_addr_o   = w_wr_addr;
  assign bus.wr_data_o   = w_wr_data;
  assign pend_o          = r_pend;
  assign irq_o           = |r_pend;
  assign busy_o          = (r_state != S_IDLE);
endmodule

// File: tb/tb_clint_timecmp_sched.sv
// Directed bench for clint_timecmp_sched: mtimecmp write sequences, expiry,
// pend W1C, stalled writes with deferred irq, and mid-sequence reset.
module tb_clint_timecmp_sched;
  localparam logic [31:0] A_LO = 32'h0200_4000;
  localparam logic [31:0] A_HI = 32'h0200_4004;

  logic        clk = 1'b0;
  logic        ndmreset_n;
  logic [63:0] mtime;
  logic        timer_irq;
  logic [3:0]  pend_clr;
  logic [3:0]  pend;
  logic        irq;
  logic        busy;
  logic [15:0] spur;
  int          checks = 0;
  int          errors = 0;
  int          wr_beats = 0;
  int          beats0;
  int          cyc;
  logic        stable;
  logic [15:0] spur_exp3, spur_exp4;

  clint_timecmp_sched_if #(.NUM_TIMERS(4)) bus ();

  clint_timecmp_sched #(
    .NUM_TIMERS(4), .CLINT_BASE(32'h0200_0000), .HART_ID(0)
  ) dut (
    .clk(clk), .ndmreset_n(ndmreset_n), .bus(bus), .mtime_i(mtime),
    .timer_irq_i(timer_irq), .pend_clr_i(pend_clr), .pend_o(pend),
    .irq_o(irq), .busy_o(busy), .spurious_cnt_o(spur)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ndmreset_n && bus.wr_valid_o && bus.wr_ready_i) wr_beats <= wr_beats + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] idx, input logic arm, input logic [63:0] dl);
    int n;
    n = 0;
    @(negedge clk);
    bus.cfg_idx_i = idx; bus.cfg_arm_i = arm; bus.cfg_deadline_i = dl; bus.cfg_valid_i = 1'b1;
    while (bus.cfg_ready_o !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("cfg_ready", bus.cfg_ready_o, 1);
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input logic [31:0] a, input logic [31:0] d, output int c);
    c = 0;
    while (bus.wr_valid_o !== 1'b1 && c < 60) begin @(negedge clk); c++; end
    chk({tag, "_valid"}, bus.wr_valid_o, 1);
    chk({tag, "_addr"}, bus.wr_addr_o, a);
    chk({tag, "_data"}, bus.wr_data_o, d);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic irq_pulse();
    @(negedge clk); timer_irq = 1'b1;
    @(negedge clk); timer_irq = 1'b0;
  endtask

  task automatic ff_triple(input string tag);
    int c;
    wait_wr({tag, "_lomax"}, A_LO, 32'hFFFF_FFFF, c);
    wait_wr({tag, "_hi"},    A_HI, 32'hFFFF_FFFF, c);
    wait_wr({tag, "_lo"},    A_LO, 32'hFFFF_FFFF, c);
  endtask

  initial begin
`ifdef CLINT_SCHED_SPURIOUS_CNT_EN
    spur_exp3 = 16'd3; spur_exp4 = 16'd4;
`else
    spur_exp3 = 16'd0; spur_exp4 = 16'd0;
`endif
    ndmreset_n = 1'b0; mtime = '0; timer_irq = 1'b0; pend_clr = '0;
    bus.cfg_valid_i = 1'b0; bus.cfg_idx_i = '0; bus.cfg_arm_i = 1'b0;
    bus.cfg_deadline_i = '0; bus.wr_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pend", pend, 0);
    chk("rst_irq", irq, 0);
    chk("rst_wr_valid", bus.wr_valid_o, 0);
    chk("rst_wr_addr", bus.wr_addr_o, 0);
    chk("rst_wr_data", bus.wr_data_o, 0);
    chk("rst_spur", spur, 0);
    ndmreset_n = 1'b1; bus.wr_ready_i = 1'b1;
    ff_triple("boot");
    wait_idle("boot_idle");

    // arm slot1 from mtime 0, then a later slot2 that leaves the min alone
    cfg(2'd1, 1'b1, 64'h1_0000_0100);
    wait_wr("s1_lomax", A_LO, 32'hFFFF_FFFF, cyc);
    chk("latency", cyc, 5);
    wait_wr("s1_hi", A_HI, 32'h0000_0001, cyc);
    wait_wr("s1_lo", A_LO, 32'h0000_0100, cyc);
    wait_idle("s1_idle");
    beats0 = wr_beats;
    cfg(2'd2, 1'b1, 64'h2_0000_0000);
    wait_idle("s2_idle");
    chk("s2_no_write", wr_beats - beats0, 0);

    // slot1 expires
    mtime = 64'h1_0000_0100;
    irq_pulse();
    wait_wr("exp1_lomax", A_LO, 32'hFFFF_FFFF, cyc);
    wait_wr("exp1_hi", A_HI, 32'h0000_0002, cyc);
    wait_wr("exp1_lo", A_LO, 32'h0000_0000, cyc);
    wait_idle("exp1_idle");
    chk("exp1_pend", pend, 4'b0010);
    chk("exp1_irq", irq, 1);
    @(negedge clk); pend_clr = 4'b0010;
    @(negedge clk); pend_clr = 4'b0000;
    chk("clr1_pend", pend, 0);
    chk("clr1_irq", irq, 0);

    // equal deadlines on slots 0 and 3
    mtime = '0;
    cfg(2'd2, 1'b0, 64'h0);
    ff_triple("dis2");
    wait_idle("dis2_idle");
    cfg(2'd0, 1'b1, 64'h500);
    wait_wr("s0_lomax", A_LO, 32'hFFFF_FFFF, cyc);
    wait_wr("s0_hi", A_HI, 32'h0000_0000, cyc);
    wait_wr("s0_lo", A_LO, 32'h0000_0500, cyc);
    wait_idle("s0_idle");
    beats0 = wr_beats;
    cfg(2'd3, 1'b1, 64'h500);
    wait_idle("s3_idle");
    chk("s3_no_write", wr_beats - beats0, 0);
    mtime = 64'h500;
    irq_pulse();
    ff_triple("tie");
    wait_idle("tie_idle");
    chk("tie_pend", pend, 4'b1001);
    @(negedge clk); pend_clr = 4'b1001;
    @(negedge clk); pend_clr = 4'b0000;
    chk("clr2_pend", pend, 0);

    // irqs with nothing armed: no expiry, no write
    beats0 = wr_beats;
    repeat (3) begin
      irq_pulse();
      wait_idle("spur_idle");
    end
    chk("spur3", spur, spur_exp3);
    chk("spur_no_write", wr_beats - beats0, 0);

    // arming an already-past deadline; clear in the EXPIRE cycle loses to set
    beats0 = wr_beats;
    cfg(2'd0, 1'b1, 64'h100);
    pend_clr = 4'b0001;
    @(negedge clk); pend_clr = 4'b0000;
    chk("setwins_pend", pend, 4'b0001);
    wait_idle("past_idle");
    chk("past_no_write", wr_beats - beats0, 0);
    @(negedge clk); pend_clr = 4'b0001;
    @(negedge clk); pend_clr = 4'b0000;
    chk("clr3_pend", pend, 0);

    // stalled WR_HI with an irq arriving mid-write
    beats0 = wr_beats;
    bus.wr_ready_i = 1'b0;
    cfg(2'd1, 1'b1, 64'h3_0000_0000);
    wait_wr("st_lomax", A_LO, 32'hFFFF_FFFF, cyc);
    bus.wr_ready_i = 1'b1;
    @(negedge clk);
    bus.wr_ready_i = 1'b0; timer_irq = 1'b1; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.wr_valid_o !== 1'b1 || bus.wr_addr_o !== A_HI || bus.wr_data_o !== 32'h3) stable = 1'b0;
      @(negedge clk);
      timer_irq = 1'b0;
    end
    chk("st_hi_stable", stable, 1);
    chk("st_cfg_ready", bus.cfg_ready_o, 0);
    bus.wr_ready_i = 1'b1;
    @(negedge clk);
    wait_wr("st_lo", A_LO, 32'h0, cyc);
    chk("st_idle_gap", busy, 0);
    @(negedge clk);
    chk("st_second_expire", busy, 1);
    wait_idle("st_idle");
    chk("st_beats", wr_beats - beats0, 3);
    chk("spur4", spur, spur_exp4);

    // reset in the middle of a write sequence
    cfg(2'd2, 1'b1, 64'h100);
    wait_idle("pre_rst_idle");
    chk("pre_rst_pend", pend, 4'b0100);
    bus.wr_ready_i = 1'b0;
    cfg(2'd0, 1'b1, 64'h1000);
    wait_wr("mr_lomax", A_LO, 32'hFFFF_FFFF, cyc);
    ndmreset_n = 1'b0;
    #1;
    chk("mr_wr_valid", bus.wr_valid_o, 0);
    chk("mr_wr_addr", bus.wr_addr_o, 0);
    chk("mr_pend", pend, 0);
    chk("mr_irq", irq, 0);
    chk("mr_spur", spur, 0);
    @(negedge clk);
    ndmreset_n = 1'b1; bus.wr_ready_i = 1'b1;
    ff_triple("mr_boot");
    wait_idle("mr_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
